// File: rtl/sram_wb_bridge.sv
// sram_wb_bridge: Wishbone-classic responder driving port 0 (RW) of the
// sky130 OpenRAM 1RW1R macro. Translates bus reads and byte-masked writes
// into the macro's active-low csb/web pin protocol and can zero-fill the
// whole array after reset before serving any request.
module sram_wb_bridge #(
    parameter int AW             = 8,
    parameter int DW             = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_wb_adr,
    input  logic [DW-1:0] i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_stb,
    output logic [DW-1:0] o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_busy,
    output logic          o_sram_csb,
    output logic          o_sram_web,
    output logic [3:0]    o_sram_wmask,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_din,
    input  logic [DW-1:0] i_sram_dout
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD1,
        S_RD2,
        S_WR,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic          csb_q, csb_d;
    logic          web_q, web_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rdt_q, rdt_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;

    // Next-state and next-output logic; every output holds unless a state changes it.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        csb_d     = csb_q;
        web_d     = web_q;
        wmask_d   = wmask_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rdt_d     = rdt_q;
        ack_d     = ack_q;
        busy_d    = busy_q;

        case (state_q)
            S_CLEAR: begin
                // The extra counter bit marks that the last word has been driven.
                if (clr_cnt_q[AW]) begin
                    csb_d   = 1'b1;
                    web_d   = 1'b1;
                    wmask_d = 4'h0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    csb_d     = 1'b0;
                    web_d     = 1'b0;
                    wmask_d   = 4'hF;
                    din_d     = '0;
                    addr_d    = clr_cnt_q[AW-1:0];
                    clr_cnt_d = clr_cnt_q + (AW+1)'(1);
                end
            end
            S_IDLE: begin
                if (i_wb_stb) begin
                    csb_d  = 1'b0;
                    addr_d = i_wb_adr;
                    if (i_wb_we) begin
                        web_d   = 1'b0;
                        wmask_d = i_wb_sel;
                        din_d   = i_wb_dat;
                        state_d = S_WR;
                    end else begin
                        web_d   = 1'b1;
                        state_d = S_RD1;
                    end
                end
            end
            S_RD1: begin
                // Macro has sampled the read; release the pins while data settles.
                csb_d   = 1'b1;
                web_d   = 1'b1;
                state_d = S_RD2;
            end
            S_RD2: begin
                rdt_d   = i_sram_dout;
                ack_d   = 1'b1;
                state_d = S_ACK;
            end
            S_WR: begin
                csb_d   = 1'b1;
                web_d   = 1'b1;
                wmask_d = 4'h0;
                ack_d   = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: begin
                // One dead edge so a master still holding stb is not served twice.
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction and restarts the fill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_cnt_q <= '0;
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            wmask_q   <= 4'h0;
            addr_q    <= '0;
            din_q     <= '0;
            rdt_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= CLEAR_ON_RESET;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            csb_q     <= csb_d;
            web_q     <= web_d;
            wmask_q   <= wmask_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rdt_q     <= rdt_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign o_wb_rdt     = rdt_q;
    assign o_wb_ack     = ack_q;
    assign o_busy       = busy_q;
    assign o_sram_csb   = csb_q;
    assign o_sram_web   = web_q;
    assign o_sram_wmask = wmask_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_din   = din_q;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// tb_sram_wb_bridge: drives sram_wb_bridge against a behavioural model of the
// OpenRAM macro's RW port and checks bus results against a word-array model.
module tb_sram_wb_bridge;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [AW-1:0] i_wb_adr;
    logic [DW-1:0] i_wb_dat;
    logic [3:0]    i_wb_sel;
    logic          i_wb_we;
    logic          i_wb_stb;
    logic [DW-1:0] o_wb_rdt;
    logic          o_wb_ack;
    logic          o_busy;
    logic          o_sram_csb;
    logic          o_sram_web;
    logic [3:0]    o_sram_wmask;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] o_sram_din;
    logic [DW-1:0] i_sram_dout;

    int vectors     = 0;
    int miscompares = 0;

    // Free-running clock shared by the bridge and the macro model.
    always #5 i_clk = ~i_clk;

    sram_wb_bridge #(
        .AW            (AW),
        .DW            (DW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wb_adr    (i_wb_adr),
        .i_wb_dat    (i_wb_dat),
        .i_wb_sel    (i_wb_sel),
        .i_wb_we     (i_wb_we),
        .i_wb_stb    (i_wb_stb),
        .o_wb_rdt    (o_wb_rdt),
        .o_wb_ack    (o_wb_ack),
        .o_busy      (o_busy),
        .o_sram_csb  (o_sram_csb),
        .o_sram_web  (o_sram_web),
        .o_sram_wmask(o_sram_wmask),
        .o_sram_addr (o_sram_addr),
        .o_sram_din  (o_sram_din),
        .i_sram_dout (i_sram_dout)
    );

    // Macro model: pins sampled on the rising edge, array written or read on the falling edge.
    logic [DW-1:0] sram_mem [DEPTH];
    logic          preload_req;
    logic          mac_csb, mac_web;
    logic [3:0]    mac_mask;
    logic [AW-1:0] mac_addr;
    logic [DW-1:0] mac_din;

    // Capture what the bridge drove before this edge.
    always @(posedge i_clk) begin
        mac_csb  <= o_sram_csb;
        mac_web  <= o_sram_web;
        mac_mask <= o_sram_wmask;
        mac_addr <= o_sram_addr;
        mac_din  <= o_sram_din;
    end

    // Perform the sampled access; preload fills the array with a recognisable pattern.
    always @(negedge i_clk) begin
        if (preload_req) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 32'hDEADBEEF;
        end else if (!mac_csb && !mac_web) begin
            for (int b = 0; b < 4; b++)
                if (mac_mask[b]) sram_mem[mac_addr][8*b +: 8] <= mac_din[8*b +: 8];
        end else if (!mac_csb) begin
            i_sram_dout <= sram_mem[mac_addr];
        end
    end

    // Count csb-low cycles and ack-high cycles as seen at each rising edge.
    int csb_low_cnt = 0;
    int ack_cnt     = 0;
    always @(posedge i_clk) begin
        if (!o_sram_csb) csb_low_cnt <= csb_low_cnt + 1;
        if (o_wb_ack)    ack_cnt     <= ack_cnt + 1;
    end

    // Reference model of the array contents and of the last read value on the bus.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rdt;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [3:0]    sel;
        logic [DW-1:0] exp_rdt;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_csb"},   32'(o_sram_csb),   32'd1);
        checkOutput({tag, "_web"},   32'(o_sram_web),   32'd1);
        checkOutput({tag, "_wmask"}, 32'(o_sram_wmask), 32'd0);
        checkOutput({tag, "_addr"},  32'(o_sram_addr),  32'd0);
        checkOutput({tag, "_din"},   o_sram_din,        32'd0);
        checkOutput({tag, "_rdt"},   o_wb_rdt,          32'd0);
        checkOutput({tag, "_ack"},   32'(o_wb_ack),     32'd0);
        checkOutput({tag, "_busy"},  32'(o_busy),       32'd1);
    endtask

    // Present one request, wait (bounded) for its ack, then step through the ack-recovery edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                 input logic [3:0] sel, output logic [DW-1:0] rdt, output int lat,
                                 output bit got, output logic ack_tail);
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_stb = 1'b1;
        tick();
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            tick();
            lat++;
            if (o_wb_ack) got = 1'b1;
        end
        rdt = o_wb_rdt;
        tick();
        ack_tail = o_wb_ack;
    endtask

    task automatic runTxn(input string tag, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [3:0] sel, input logic [DW-1:0] exp_rdt);
        logic [DW-1:0] rdt;
        int            lat;
        bit            got;
        logic          ack_tail;
        applyStimulus(we, adr, dat, sel, rdt, lat, got, ack_tail);
        checkOutput({tag, "_ack"},     32'(got),      32'd1);
        checkOutput({tag, "_latency"}, 32'(lat),      we ? 32'd1 : 32'd2);
        checkOutput({tag, "_rdt"},     rdt,           exp_rdt);
        checkOutput({tag, "_ackwidth"}, 32'(ack_tail), 32'd0);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr][8*b +: 8] = dat[8*b +: 8];
        end else begin
            ref_rdt = ref_mem[adr];
        end
    endtask

    task automatic zeroModel();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_rdt = '0;
    endtask

    // Wait for a restarted fill to finish, returning how many edges o_busy stayed high.
    task automatic waitClear(output int busy_cnt);
        busy_cnt = 0;
        for (int e = 0; e < 600; e++) begin
            tick();
            if (e == 0) begin
                checkOutput("refill_first_addr", 32'(o_sram_addr), 32'd0);
                checkOutput("refill_first_csb",  32'(o_sram_csb),  32'd0);
            end
            if (!o_busy) break;
            busy_cnt++;
        end
    endtask

    // Watchdog so the run always ends even if a wait loop misbehaves.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            busy_cnt;
        int            ack_edge;
        int            early_ack;
        int            csb0;
        int            ack0;
        logic [DW-1:0] first_rdt;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [3:0]    s;
        logic          w;

        i_rst       = 1'b1;
        i_wb_stb    = 1'b0;
        i_wb_we     = 1'b0;
        i_wb_adr    = '0;
        i_wb_dat    = '0;
        i_wb_sel    = '0;
        preload_req = 1'b1;
        zeroModel();

        vecs[0] = '{1'b1, 8'h05, 32'h12345678, 4'hF, 32'h00000000};
        vecs[1] = '{1'b0, 8'h05, 32'h00000000, 4'h0, 32'h12345678};
        vecs[2] = '{1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 32'h12345678};
        vecs[3] = '{1'b1, 8'h10, 32'h11223344, 4'h5, 32'h12345678};
        vecs[4] = '{1'b0, 8'h10, 32'h00000000, 4'h0, 32'hAA22CC44};
        vecs[5] = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'hAA22CC44};
        vecs[6] = '{1'b0, 8'h10, 32'h00000000, 4'h0, 32'hAA22CC44};
        vecs[7] = '{1'b1, 8'h11, 32'h99887766, 4'h8, 32'hAA22CC44};
        vecs[8] = '{1'b0, 8'h11, 32'h00000000, 4'h0, 32'h99000000};
        vecs[9] = '{1'b0, 8'h05, 32'h00000000, 4'h0, 32'h12345678};

        repeat (3) tick();
        checkResetValues("reset");

        // Release reset with a read of 0x03 already pending; it must wait for the fill.
        preload_req = 1'b0;
        i_rst       = 1'b0;
        i_wb_stb    = 1'b1;
        i_wb_we     = 1'b0;
        i_wb_adr    = 8'h03;
        busy_cnt    = 0;
        ack_edge    = -1;
        early_ack   = 0;
        first_rdt   = '1;
        csb0        = csb_low_cnt;
        for (int e = 0; e < 400 && ack_edge < 0; e++) begin
            tick();
            if (o_busy) busy_cnt++;
            if (o_wb_ack) begin
                if (o_busy) early_ack = 1;
                ack_edge  = e;
                first_rdt = o_wb_rdt;
            end
            if (e == 0) begin
                checkOutput("clear_first_addr",  32'(o_sram_addr),  32'd0);
                checkOutput("clear_first_csb",   32'(o_sram_csb),   32'd0);
                checkOutput("clear_first_web",   32'(o_sram_web),   32'd0);
                checkOutput("clear_first_wmask", 32'(o_sram_wmask), 32'hF);
                checkOutput("clear_first_din",   o_sram_din,        32'd0);
            end
            if (e == 100) checkOutput("clear_addr_100", 32'(o_sram_addr), 32'd100);
            if (e == 255) checkOutput("clear_addr_255", 32'(o_sram_addr), 32'd255);
            if (e == 256) begin
                checkOutput("clear_end_csb",  32'(o_sram_csb), 32'd1);
                checkOutput("clear_end_busy", 32'(o_busy),     32'd0);
            end
        end
        checkOutput("clear_busy_cycles",   32'(busy_cnt),              32'd256);
        checkOutput("clear_early_ack",     32'(early_ack),             32'd0);
        checkOutput("pending_rd_ack_edge", 32'(ack_edge),              32'd259);
        checkOutput("pending_rd_data",     first_rdt,                  32'd0);
        checkOutput("clear_csb_cycles",    32'(csb_low_cnt - csb0),    32'd257);
        tick();
        checkOutput("pending_rd_ackwidth", 32'(o_wb_ack), 32'd0);
        i_wb_stb = 1'b0;
        tick();

        // Preloaded pattern must be gone everywhere.
        runTxn("zero_0x7F", 1'b0, 8'h7F, '0, '0, 32'd0);
        i_wb_stb = 1'b0; tick();
        runTxn("zero_0xFF", 1'b0, 8'hFF, '0, '0, 32'd0);
        i_wb_stb = 1'b0; tick();
        runTxn("zero_0x00", 1'b0, 8'h00, '0, '0, 32'd0);
        i_wb_stb = 1'b0; tick();

        // Directed table: write/read, byte masks and a null-mask write.
        for (int i = 0; i < 10; i++) begin
            runTxn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_rdt);
            i_wb_stb = 1'b0;
            tick();
        end

        // Back-to-back with stb held: alternating write/read over 0x00..0x0F.
        ack0 = ack_cnt;
        csb0 = csb_low_cnt;
        for (int i = 0; i < 16; i++) begin
            a = AW'(i);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            runTxn($sformatf("b2b_wr%0d", i), 1'b1, a, d, s, ref_rdt);
            runTxn($sformatf("b2b_rd%0d", i), 1'b0, a, '0, '0, ref_mem[a]);
        end
        i_wb_stb = 1'b0;
        tick();
        checkOutput("b2b_ack_count", 32'(ack_cnt - ack0),     32'd32);
        checkOutput("b2b_csb_count", 32'(csb_low_cnt - csb0), 32'd32);

        // Randomized traffic against the reference model, with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 31));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            runTxn($sformatf("rnd%0d", i), w, a, d, s, w ? ref_rdt : ref_mem[a]);
            i_wb_stb = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        // Reset pulse in the middle of a fill restarts it from address 0.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (100) tick();
        checkOutput("midclear_addr_99", 32'(o_sram_addr), 32'd99);
        i_rst = 1'b1;
        tick();
        checkResetValues("midclear_reset");
        i_rst = 1'b0;
        waitClear(busy_cnt);
        checkOutput("midclear_busy_cycles", 32'(busy_cnt), 32'd256);
        zeroModel();
        tick();
        runTxn("midclear_zero_0x05", 1'b0, 8'h05, '0, '0, 32'd0);
        i_wb_stb = 1'b0; tick();

        // Reset while a read sits in RD1: no ack, csb released, then a fresh fill.
        runTxn("pre_rd1_wr", 1'b1, 8'h20, 32'h5A5AA5A5, 4'hF, ref_rdt);
        i_wb_stb = 1'b0; tick();
        i_wb_we  = 1'b0;
        i_wb_adr = 8'h20;
        i_wb_stb = 1'b1;
        ack0     = ack_cnt;
        tick();
        checkOutput("rd1_csb_low", 32'(o_sram_csb), 32'd0);
        i_rst = 1'b1;
        tick();
        checkOutput("rd1_reset_csb", 32'(o_sram_csb), 32'd1);
        checkOutput("rd1_reset_ack", 32'(o_wb_ack),   32'd0);
        i_rst    = 1'b0;
        i_wb_stb = 1'b0;
        waitClear(busy_cnt);
        checkOutput("rd1_refill_busy",  32'(busy_cnt),          32'd256);
        checkOutput("rd1_no_ack",       32'(ack_cnt - ack0),    32'd0);
        zeroModel();
        tick();
        runTxn("rd1_after_0x20", 1'b0, 8'h20, '0, '0, 32'd0);
        i_wb_stb = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
